// File: rtl/axi_sram_responder.sv
// AXI slave memory model backing a word-addressed internal RAM.
// One outstanding read and one outstanding write, serviced concurrently.
module axi_sram_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1fc0_0000,
    parameter int          DEPTH_LOG2 = 14,
    parameter int          ID_W       = 4
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic [1:0]      arlock,
    input  logic [3:0]      arcache,
    input  logic [2:0]      arprot,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic [1:0]      awlock,
    input  logic [3:0]      awcache,
    input  logic [2:0]      awprot,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ID_W-1:0] wid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    output logic [31:0]     statistic_read_beats,
    output logic [31:0]     statistic_write_beats
);
    typedef enum logic {R_IDLE, R_BURST} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [31:0] SPAN  = 32'd4 << DEPTH_LOG2;

    logic [31:0] r_mem [DEPTH];

    function automatic logic [31:0] f_next_addr(
        input logic [31:0] a, input logic [2:0] sz,
        input logic [7:0] len, input logic [1:0] bu);
        logic [31:0] step;
        logic [31:0] bound;
        logic        wrap_ok;
        step    = 32'd1 << sz;
        bound   = ({24'd0, len} + 32'd1) << sz;
        wrap_ok = (len == 8'd1) || (len == 8'd3) ||
                  (len == 8'd7) || (len == 8'd15);
        if (bu == 2'b00)
            return a;
        else if (bu == 2'b10 && wrap_ok)
            return (a & ~(bound - 32'd1)) |
                   ((a + step) & (bound - 32'd1));
        else
            return a + step;
    endfunction

    function automatic logic f_in_range(input logic [31:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] f_idx(input logic [31:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
    endfunction

    // ---------------- read channel ----------------
    rstate_t         r_rstate;
    rstate_t         w_rnext;
    logic            r_arready;
    logic            r_rvalid;
    logic            r_rlast;
    logic [31:0]     r_rdata;
    logic [1:0]      r_rresp;
    logic [ID_W-1:0] r_rid;
    logic [31:0]     r_raddr;
    logic [7:0]      r_rlen;
    logic [7:0]      r_rcnt;
    logic [2:0]      r_rsize;
    logic [1:0]      r_rburst;
    logic [31:0]     r_rbeats;

    logic            w_arfire;
    logic            w_rfire;
    logic [31:0]     w_raddr_nx;
    logic [31:0]     w_rload_addr;
    logic            w_rload_ok;
    logic [31:0]     w_rload_data;

    assign w_arfire     = arvalid && r_arready;
    assign w_rfire      = r_rvalid && rready;
    assign w_raddr_nx   = f_next_addr(r_raddr, r_rsize, r_rlen, r_rburst);
    assign w_rload_addr = w_arfire ? araddr : w_raddr_nx;
    assign w_rload_ok   = f_in_range(w_rload_addr);
    assign w_rload_data = w_rload_ok ? r_mem[f_idx(w_rload_addr)] : 32'd0;

    // read FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_rstate <= R_IDLE;
        else          r_rstate <= w_rnext;
    end

    // read FSM next state
    always_comb begin
        w_rnext = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (w_arfire) w_rnext = R_BURST;
            R_BURST: if (w_rfire && r_rlast) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    // read burst tracking and registered R beat, next beat loaded on handshake
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= '0;
            r_rid     <= '0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rsize   <= '0;
            r_rburst  <= '0;
            r_rbeats  <= '0;
        end else begin
            r_arready <= (w_rnext == R_IDLE);
            if (w_rfire) r_rbeats <= r_rbeats + 32'd1;
            if (w_arfire) begin
                r_rid    <= arid;
                r_raddr  <= araddr;
                r_rlen   <= arlen;
                r_rsize  <= (arsize > 3'd2) ? 3'd2 : arsize;
                r_rburst <= arburst;
                r_rcnt   <= '0;
                r_rvalid <= 1'b1;
                r_rlast  <= (arlen == 8'd0);
                r_rdata  <= w_rload_data;
                r_rresp  <= w_rload_ok ? 2'b00 : 2'b10;
            end else if (w_rfire) begin
                if (r_rlast) begin
                    r_rvalid <= 1'b0;
                end else begin
                    r_raddr <= w_raddr_nx;
                    r_rcnt  <= r_rcnt + 8'd1;
                    r_rlast <= (r_rcnt + 8'd1 == r_rlen);
                    r_rdata <= w_rload_data;
                    r_rresp <= w_rload_ok ? 2'b00 : 2'b10;
                end
            end
        end
    end

    // ---------------- write channel ----------------
    wstate_t         r_wstate;
    wstate_t         w_wnext;
    logic            r_awready;
    logic            r_wready;
    logic            r_bvalid;
    logic [1:0]      r_bresp;
    logic [ID_W-1:0] r_bid;
    logic [ID_W-1:0] r_wid;
    logic [31:0]     r_waddr;
    logic [7:0]      r_wlen;
    logic [7:0]      r_wcnt;
    logic [2:0]      r_wsize;
    logic [1:0]      r_wburst;
    logic            r_werr;
    logic [31:0]     r_wbeats;

    logic            w_awfire;
    logic            w_wfire;
    logic            w_bfire;
    logic            w_wend;
    logic            w_win;
    logic            w_wbeat_err;

    assign w_awfire    = awvalid && r_awready;
    assign w_wfire     = wvalid && r_wready;
    assign w_bfire     = r_bvalid && bready;
    assign w_wend      = (r_wcnt == r_wlen);
    assign w_win       = f_in_range(r_waddr);
    assign w_wbeat_err = !w_win || (wlast != w_wend);

    // write FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_wstate <= W_IDLE;
        else          r_wstate <= w_wnext;
    end

    // write FSM next state; burst length comes from awlen, not wlast
    always_comb begin
        w_wnext = r_wstate;
        unique case (r_wstate)
            W_IDLE:  if (w_awfire) w_wnext = W_DATA;
            W_DATA:  if (w_wfire && w_wend) w_wnext = W_RESP;
            W_RESP:  if (w_bfire) w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    // write burst tracking, error accumulation and B response
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= '0;
            r_bid     <= '0;
            r_wid     <= '0;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_wsize   <= '0;
            r_wburst  <= '0;
            r_werr    <= 1'b0;
            r_wbeats  <= '0;
        end else begin
            r_awready <= (w_wnext == W_IDLE);
            r_wready  <= (w_wnext == W_DATA);
            if (w_awfire) begin
                r_wid    <= awid;
                r_waddr  <= awaddr;
                r_wlen   <= awlen;
                r_wsize  <= (awsize > 3'd2) ? 3'd2 : awsize;
                r_wburst <= awburst;
                r_wcnt   <= '0;
                r_werr   <= 1'b0;
            end
            if (w_wfire) begin
                r_wbeats <= r_wbeats + 32'd1;
                r_waddr  <= f_next_addr(r_waddr, r_wsize, r_wlen, r_wburst);
                r_wcnt   <= r_wcnt + 8'd1;
                r_werr   <= r_werr | w_wbeat_err;
                if (w_wend) begin
                    r_bvalid <= 1'b1;
                    r_bid    <= r_wid;
                    r_bresp  <= (r_werr | w_wbeat_err) ? 2'b10 : 2'b00;
                end
            end
            if (w_bfire) r_bvalid <= 1'b0;
        end
    end

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge aclk) begin
        if (w_wfire && w_win) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) r_mem[f_idx(r_waddr)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    logic w_unused;
    assign w_unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    assign arready               = r_arready;
    assign rvalid                = r_rvalid;
    assign rlast                 = r_rlast;
    assign rdata                 = r_rdata;
    assign rresp                 = r_rresp;
    assign rid                   = r_rid;
    assign awready               = r_awready;
    assign wready                = r_wready;
    assign bvalid                = r_bvalid;
    assign bresp                 = r_bresp;
    assign bid                   = r_bid;
    assign statistic_read_beats  = r_rbeats;
    assign statistic_write_beats = r_wbeats;
endmodule

// File: tb/tb_axi_sram_responder.sv
// Randomized bench for axi_sram_responder.
// Expectations come from a word-array memory model and burst arithmetic.
module tb_axi_sram_responder;
    localparam logic [31:0] BASE = 32'h1fc0_0000;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] statistic_read_beats;
    logic [31:0] statistic_write_beats;

    axi_sram_responder #(
        .BASE_ADDR(BASE), .DEPTH_LOG2(14), .ID_W(4)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache),
        .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .statistic_read_beats(statistic_read_beats),
        .statistic_write_beats(statistic_write_beats)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_chk;
    int n_pass;
    int n_rb;
    int n_wb;
    logic [31:0] mm [0:16383];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rx [16];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] beat_addr(
        input logic [31:0] a, input logic [7:0] len,
        input logic [2:0] sz, input logic [1:0] bu, input int i);
        int unsigned nb;
        int unsigned tot;
        logic [31:0] lo;
        nb = 1 << ((sz > 3'd2) ? 2 : int'(sz));
        if (bu == 2'b00) return a;
        if (bu == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            tot = (int'(len) + 1) * nb;
            lo  = a - (a % tot);
            return lo + ((a - lo) + i * nb) % tot;
        end
        return a + i * nb;
    endfunction

    function automatic logic in_rng(input logic [31:0] a);
        return (a - BASE) < 32'h10000;
    endfunction

    function automatic logic [13:0] widx(input logic [31:0] a);
        return 14'((a - BASE) >> 2);
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bu, input int bad,
                            input bit hold_b);
        int t;
        logic err;
        logic [31:0] a;
        logic [31:0] cur;
        awid = id; awaddr = addr; awlen = len; awsize = sz;
        awburst = bu; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin tick(); t++; end
        check("awready", awready, 1);
        tick();
        awvalid = 1'b0;
        err = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; tick(); end
            wdata = wd[i]; wstrb = ws[i];
            wlast = (i == int'(len)) ^ (i == bad);
            wvalid = 1'b1;
            t = 0;
            while (!wready && t < 50) begin tick(); t++; end
            check("wready", wready, 1);
            tick();
            n_wb++;
            a = beat_addr(addr, len, sz, bu, i);
            if (in_rng(a)) begin
                cur = mm[widx(a)];
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) cur[8*b +: 8] = wd[i][8*b +: 8];
                mm[widx(a)] = cur;
            end else begin
                err = 1'b1;
            end
            if (wlast != (i == int'(len))) err = 1'b1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("bvalid", bvalid, 1);
        check("bid", bid, id);
        check("bresp", bresp, err ? 32'd2 : 32'd0);
        check("wr_beats", statistic_write_beats, n_wb);
        if (!hold_b) begin
            repeat ($urandom_range(0, 2)) begin
                tick();
                check("bvalid_hold", bvalid, 1);
            end
            bready = 1'b1;
            tick();
            bready = 1'b0;
            check("bvalid_clr", bvalid, 0);
            check("awready_back", awready, 1);
        end
    endtask

    // mode 0: rready always high, 1: random stalls, 2: 3-cycle stall before beat 1
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input int mode);
        int t;
        int st;
        logic [31:0] a;
        logic [31:0] ed;
        logic [1:0] er;
        arid = id; araddr = addr; arlen = len; arsize = sz;
        arburst = bu; arvalid = 1'b1;
        if (mode == 0) rready = 1'b1;
        t = 0;
        while (!arready && t < 50) begin tick(); t++; end
        check("arready", arready, 1);
        tick();
        arvalid = 1'b0;
        check("rvalid_first", rvalid, 1);
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, len, sz, bu, i);
            if (in_rng(a)) begin ed = mm[widx(a)]; er = 2'b00; end
            else begin ed = 32'd0; er = 2'b10; end
            st = (mode == 1) ? int'($urandom_range(0, 2)) :
                 (mode == 2 && i == 1) ? 3 : 0;
            if (st > 0) rready = 1'b0;
            for (int s = 0; s < st; s++) begin
                tick();
                check("rhold_valid", rvalid, 1);
                check("rhold_data", rdata, ed);
                check("rhold_last", rlast, i == int'(len));
            end
            rready = 1'b1;
            check("rvalid", rvalid, 1);
            check("rdata", rdata, ed);
            check("rresp", rresp, er);
            check("rlast", rlast, i == int'(len));
            check("rid", rid, id);
            rx[i] = rdata;
            tick();
            n_rb++;
        end
        rready = 1'b0;
        check("rvalid_end", rvalid, 0);
        check("arready_back", arready, 1);
        check("rd_beats", statistic_read_beats, n_rb);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] old_v;
        logic [31:0] new_v;
        logic [31:0] addr;
        logic [7:0]  len;
        int t;
        int bad;
        int r;
        int wb0;
        logic [7:0] lens [5];
        lens[0] = 8'd0; lens[1] = 8'd1; lens[2] = 8'd3;
        lens[3] = 8'd7; lens[4] = 8'd15;
        n_chk = 0; n_pass = 0; n_rb = 0; n_wb = 0;
        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
        rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0;

        repeat (3) tick();
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rdcnt", statistic_read_beats, 0);
        check("rst_wrcnt", statistic_write_beats, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        check("rel_arready", arready, 1);
        check("rel_awready", awready, 1);

        // prefill low window and top-of-RAM window
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(4'(k), BASE + 32'(k * 64), 8'd15, 3'd2, 2'b01, -1, 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(4'd1, BASE + 32'hFF80 + 32'(k * 64), 8'd15, 3'd2, 2'b01, -1, 1'b0);
        end

        // single read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(4'd1, BASE, 8'd0, 3'd2, 2'b01, -1, 1'b0);
        do_read(4'd3, BASE, 8'd0, 3'd2, 2'b01, 0);
        check("t1_data", rx[0], 32'hDEADBEEF);
        check("t1_rdcnt", statistic_read_beats, 1);

        // INCR write then gapless read
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(4'd2, BASE + 32'd16, 8'd3, 3'd2, 2'b01, -1, 1'b0);
        do_read(4'd2, BASE + 32'd16, 8'd3, 3'd2, 2'b01, 0);
        for (int i = 0; i < 4; i++) check("t2_data", rx[i], 32'(i + 1));

        // WRAP
        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
        do_write(4'd4, BASE, 8'd3, 3'd2, 2'b01, -1, 1'b0);
        do_read(4'd5, BASE + 32'd8, 8'd3, 3'd2, 2'b10, 0);
        check("t3_b0", rx[0], 32'hC);
        check("t3_b1", rx[1], 32'hD);
        check("t3_b2", rx[2], 32'hA);
        check("t3_b3", rx[3], 32'hB);

        // strobes and backpressure
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(4'd6, BASE + 32'd32, 8'd0, 3'd2, 2'b01, -1, 1'b0);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(4'd6, BASE + 32'd32, 8'd0, 3'd2, 2'b01, -1, 1'b0);
        do_read(4'd7, BASE + 32'd32, 8'd0, 3'd2, 2'b01, 0);
        check("t4_strb", rx[0], 32'h11BB33DD);
        do_read(4'd8, BASE, 8'd3, 3'd2, 2'b01, 2);

        // errors
        do_read(4'd9, BASE + 32'h10000, 8'd0, 3'd2, 2'b01, 0);
        check("t5_oor_data", rx[0], 32'd0);
        wb0 = n_wb;
        for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'd10, BASE + 32'd48, 8'd1, 3'd2, 2'b01, 0, 1'b0);
        check("t5_wbeats", statistic_write_beats, 32'(wb0 + 2));

        // read loaded on the same edge as a write to that word
        old_v = mm[5];
        new_v = ~old_v;
        awid = 4'd11; awaddr = BASE + 32'd20; awlen = 8'd0; awsize = 3'd2;
        awburst = 2'b01; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin tick(); t++; end
        tick();
        awvalid = 1'b0;
        check("cc_wready", wready, 1);
        check("cc_arready", arready, 1);
        arid = 4'd12; araddr = BASE + 32'd20; arlen = 8'd0; arsize = 3'd2;
        arburst = 2'b01; arvalid = 1'b1;
        wdata = new_v; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        tick();
        arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        n_wb++;
        mm[5] = new_v;
        check("cc_rvalid", rvalid, 1);
        check("cc_old", rdata, old_v);
        check("cc_bvalid", bvalid, 1);
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        n_rb++;
        check("cc_rdcnt", statistic_read_beats, n_rb);
        check("cc_wrcnt", statistic_write_beats, n_wb);
        do_read(4'd12, BASE + 32'd20, 8'd0, 3'd2, 2'b01, 0);
        check("cc_new", rx[0], new_v);

        // reset with a B response and a read burst both pending
        wd[0] = $urandom; ws[0] = 4'hF;
        do_write(4'd13, BASE + 32'd24, 8'd0, 3'd2, 2'b01, -1, 1'b1);
        arid = 4'd14; araddr = BASE; arlen = 8'd3; arsize = 3'd2;
        arburst = 2'b01; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin tick(); t++; end
        tick();
        arvalid = 1'b0;
        check("mr_rvalid", rvalid, 1);
        tick();
        #2 aresetn = 1'b0;
        #1;
        check("mr_rvalid_clr", rvalid, 0);
        check("mr_bvalid_clr", bvalid, 0);
        check("mr_arready", arready, 0);
        check("mr_awready", awready, 0);
        check("mr_rdata", rdata, 0);
        check("mr_rdcnt", statistic_read_beats, 0);
        check("mr_wrcnt", statistic_write_beats, 0);
        n_rb = 0; n_wb = 0;
        repeat (2) tick();
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        check("mr_rel_arready", arready, 1);
        check("mr_rel_awready", awready, 1);
        check("mr_rel_rvalid", rvalid, 0);
        do_read(4'd15, BASE + 32'd24, 8'd0, 3'd2, 2'b01, 0);

        // randomized traffic
        for (int it = 0; it < 80; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       addr = BASE + $urandom_range(0, 255);
            else if (r == 7) addr = BASE + 32'hFFF0 + $urandom_range(0, 3);
            else if (r == 8) addr = BASE - 32'd8;
            else             addr = BASE + 32'h20000 + $urandom_range(0, 1000);
            if ($urandom_range(0, 1) == 0) len = 8'($urandom_range(0, 15));
            else len = lens[$urandom_range(0, 4)];
            if ($urandom_range(0, 1) == 0) begin
                do_read(4'($urandom), addr, len, 3'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)), 1);
            end else begin
                for (int i = 0; i < 16; i++) begin
                    wd[i] = $urandom;
                    ws[i] = 4'($urandom);
                end
                bad = ($urandom_range(0, 4) == 0) ?
                      int'($urandom_range(0, int'(len))) : -1;
                do_write(4'($urandom), addr, len, 3'($urandom_range(0, 3)),
                         2'($urandom_range(0, 3)), bad, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axi_sram_responder.md
Name: axi_sram_responder

Overview:
- AXI slave-side memory model that answers the CPU core's AXI master port: AR/R and AW/W/B channels.
- Backs a word-addressed internal RAM.
- Sits opposite the CPU top in simulation SoCs and FPGA bring-up; replaces the external memory controller.
- Supports FIXED/INCR/WRAP bursts, byte strobes, and one outstanding read plus one outstanding write, handled concurrently.

Parameters:
- BASE_ADDR, 32'h1fc0_0000, byte address mapped to RAM word 0.
- DEPTH_LOG2, 14, RAM depth in 32-bit words (2^14 words = 64 KiB).
- ID_W, 4, width of all AXI ID fields.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  ID_W/32/8/3/2/2/4/3  read address; lock/cache/prot ignored.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rid/rdata/rresp/rlast  out  ID_W/32/2/1  read data beat.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  ID_W/32/8/3/2/2/4/3  write address; lock/cache/prot ignored.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wid/wdata/wstrb/wlast  in  ID_W/32/4/1  write data beat; wid ignored.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bid/bresp  out  ID_W/2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- statistic_read_beats  out  32  count of completed R handshakes.
- statistic_write_beats  out  32  count of completed W handshakes.

Behaviour:
- Reset:
  - aresetn low asynchronously clears both FSMs to IDLE and clears all registered outputs (arready, awready, rvalid, wready, bvalid, rlast, rdata, rid, rresp, bid, bresp, counters) to 0.
  - RAM contents are not reset.
  - arready/awready rise on the first aclk edge after aresetn goes high.
  - Reset mid-burst aborts the burst silently; no response is issued.
- Read FSM, states R_IDLE and R_BURST:
  - arready = 1 only in R_IDLE.
  - On AR handshake: latch id, addr, len, size (clamped to 2 if >2), burst; beat counter = 0; go to R_BURST.
  - rvalid = 1 on the next cycle, so the first beat appears 1 cycle after the AR handshake.
  - rdata, rresp and rlast are registered and held stable while rvalid && !rready.
  - Each R handshake advances the address and loads the next beat on the same edge, so back-to-back beats have no bubbles.
  - rlast = (beat counter == len).
  - R handshake with rlast: go to R_IDLE, rvalid = 0; arready returns 1 cycle later (no AR accept in the last-beat cycle).
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - awready = 1 only in W_IDLE.
  - AW handshake: latch fields, go to W_DATA.
  - W_DATA: wready = 1. Each W handshake writes the RAM bytes selected by wstrb and advances the address.
  - The burst ends at beat counter == len, regardless of wlast. If wlast disagrees with (counter == len) on any beat, an error flag is set.
  - End of burst: go to W_RESP. bvalid = 1 next cycle with bid = latched awid.
  - B handshake: go to W_IDLE.
- Address generation:
  - FIXED: address unchanged.
  - INCR: addr += 1<<size.
  - WRAP: bound = (len+1)<<size; addr = (addr & ~(bound-1)) | ((addr + (1<<size)) & (bound-1)).
  - WRAP with len not in {1,3,7,15} is treated as INCR.
  - burst 2'b11 (reserved) is treated as INCR.
- RAM access:
  - Word index = (addr - BASE_ADDR) >> 2, modulo 2^32.
  - In range iff (addr - BASE_ADDR) < 4<<DEPTH_LOG2.
  - Out-of-range read beat: rdata = 0, rresp = 2'b10 (SLVERR).
  - Out-of-range write beat: no RAM update; error flag set.
  - rdata is always the full 32-bit word; narrow sizes do not mask lanes.
- Responses:
  - rresp = 2'b00 (OKAY) otherwise.
  - bresp = 2'b10 if the error flag is set, else 2'b00.
- Read/write collision: a read beat loaded on the same edge as a write to that word returns the pre-write data.
- Counters: wrap modulo 2^32; increment on the R and W handshakes respectively.

Test Plan:
- Single read: preload word0 = 32'hDEADBEEF; araddr = 32'h1fc00000, arlen = 0, arsize = 2 → rvalid the cycle after AR, rdata = DEADBEEF, rlast = 1, rresp = 0, rid = arid; statistic_read_beats = 1.
- INCR write/read: awlen = 3 with data 1,2,3,4 and wstrb = F → bresp = 0; then a len-3 read returns 1,2,3,4 with rlast only on beat 3; with rready held high there are no bubbles.
- WRAP: words 0..3 = A,B,C,D; araddr = BASE+8, arlen = 3, arburst = 2 → rdata C, D, A, B.
- Strobes and backpressure: word = 0x11223344, write 0xAABBCCDD with wstrb = 4'b0101 → readback 0x11BB33DD; rready low for 3 cycles mid-burst → rdata/rlast stable.
- Errors: read at BASE+0x10000 (DEPTH_LOG2 = 14) → rresp = 2, rdata = 0. Write len = 1 with wlast on beat 0 → 2 beats accepted, bresp = 2.
- Concurrency and reset: a read burst overlapping a write to the same word returns the old value. Driving aresetn low mid-burst → rvalid/bvalid = 0 immediately; arready = awready = 1 one edge after release.
